// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - issue-stage hazard controller with per-register write-pending scoreboard
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W = 5,
  parameter int WB_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic                  id_src_a_vld,
  input  logic                  id_src_b_vld,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wr_en,
  input  logic                  id_is_load,
  input  logic                  id_is_store,
  input  logic [1:0]            id_br,
  input  logic                  br_resolved,
  input  logic                  br_taken,
  input  logic                  mem_ready,
  output logic                  issue,
  output logic                  stall_if,
  output logic                  bubble_ex,
  output logic                  stall_ex,
  output logic                  flush_ifid,
  output logic                  mem_req
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = $clog2(WB_LATENCY + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_BR_WAIT  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q [NUM_REGS];
  logic [CNT_W-1:0]      cnt_d [NUM_REGS];
  logic [REG_ADDR_W-1:0] load_rd_q, load_rd_d;
  logic                  load_hold_q, load_hold_d;

  logic src_a_busy, src_b_busy, hazard;
  logic alu_wr, load_done;
  logic issue_c, stall_if_c, bubble_ex_c, stall_ex_c, flush_ifid_c, mem_req_c;

  // A held load destination reads as busy even though its counter is not yet armed.
  assign src_a_busy = (cnt_q[id_src_a] != '0) || (load_hold_q && (id_src_a == load_rd_q));
  assign src_b_busy = (cnt_q[id_src_b] != '0) || (load_hold_q && (id_src_b == load_rd_q));
  assign hazard     = (id_src_a_vld && src_a_busy) || (id_src_b_vld && src_b_busy);

  always_comb begin
    state_d      = state_q;
    load_rd_d    = load_rd_q;
    load_hold_d  = load_hold_q;
    issue_c      = 1'b0;
    stall_if_c   = 1'b0;
    bubble_ex_c  = 1'b0;
    stall_ex_c   = 1'b0;
    flush_ifid_c = 1'b0;
    mem_req_c    = 1'b0;
    alu_wr       = 1'b0;
    load_done    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (id_valid) begin
          if (hazard) begin
            stall_if_c  = 1'b1;
            bubble_ex_c = 1'b1;
          end else begin
            issue_c = 1'b1;
            if (id_is_load || id_is_store) begin
              state_d = ST_MEM_WAIT;
              if (id_is_load) begin
                load_rd_d   = id_rd;
                load_hold_d = 1'b1;
              end
            end else begin
              alu_wr = id_wr_en;
              if (id_br != 2'b00) begin
                state_d = ST_BR_WAIT;
              end
            end
          end
        end
      end
      ST_MEM_WAIT: begin
        mem_req_c  = 1'b1;
        stall_if_c = 1'b1;
        stall_ex_c = 1'b1;
        if (mem_ready) begin
          state_d     = ST_RUN;
          load_done   = load_hold_q;
          load_hold_d = 1'b0;
        end
      end
      ST_BR_WAIT: begin
        stall_if_c  = 1'b1;
        bubble_ex_c = 1'b1;
        if (br_resolved) begin
          flush_ifid_c = br_taken;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Returning load data becomes readable one cycle after mem_ready.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_d[i] = cnt_q[i];
      if ((cnt_q[i] != '0) && !(load_hold_q && (load_rd_q == REG_ADDR_W'(i)))) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
    if (alu_wr) begin
      cnt_d[id_rd] = CNT_W'(WB_LATENCY);
    end
    if (load_done) begin
      cnt_d[load_rd_q] = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      load_rd_q   <= '0;
      load_hold_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      load_rd_q   <= load_rd_d;
      load_hold_q <= load_hold_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign issue      = reset & issue_c;
  assign stall_if   = reset & stall_if_c;
  assign bubble_ex  = reset & bubble_ex_c;
  assign stall_ex   = reset & stall_ex_c;
  assign flush_ifid = reset & flush_ifid_c;
  assign mem_req    = reset & mem_req_c;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;

  localparam int AW = 5;

  // Output vector order: {issue, stall_if, bubble_ex, stall_ex, flush_ifid, mem_req}
  localparam logic [5:0] E_NONE  = 6'b000000;
  localparam logic [5:0] E_ISSUE = 6'b100000;
  localparam logic [5:0] E_HAZ   = 6'b011000;
  localparam logic [5:0] E_MEM   = 6'b010101;
  localparam logic [5:0] E_BR    = 6'b011000;
  localparam logic [5:0] E_BRF   = 6'b011010;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid = 1'b0;
  logic [AW-1:0] id_src_a = '0;
  logic [AW-1:0] id_src_b = '0;
  logic          id_src_a_vld = 1'b0;
  logic          id_src_b_vld = 1'b0;
  logic [AW-1:0] id_rd = '0;
  logic          id_wr_en = 1'b0;
  logic          id_is_load = 1'b0;
  logic          id_is_store = 1'b0;
  logic [1:0]    id_br = 2'b00;
  logic          br_resolved = 1'b0;
  logic          br_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          issue, stall_if, bubble_ex, stall_ex, flush_ifid, mem_req;

  logic          s_reset = 1'b0;
  logic          s_valid = 1'b0;
  logic [AW-1:0] s_sa = '0;
  logic [AW-1:0] s_sb = '0;
  logic          s_sav = 1'b0;
  logic          s_sbv = 1'b0;
  logic [AW-1:0] s_rd = '0;
  logic          s_wr = 1'b0;
  logic          s_ld = 1'b0;
  logic          s_st = 1'b0;
  logic [1:0]    s_br = 2'b00;
  logic          s_brres = 1'b0;
  logic          s_brtk = 1'b0;
  logic          s_mrdy = 1'b0;

  string      name_q [$];
  logic [5:0] val_q  [$];
  int         n_total = 0;
  int         n_pass  = 0;

  pipeline_hazard_controller #(
    .REG_ADDR_W(AW),
    .WB_LATENCY(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_src_a     (id_src_a),
    .id_src_b     (id_src_b),
    .id_src_a_vld (id_src_a_vld),
    .id_src_b_vld (id_src_b_vld),
    .id_rd        (id_rd),
    .id_wr_en     (id_wr_en),
    .id_is_load   (id_is_load),
    .id_is_store  (id_is_store),
    .id_br        (id_br),
    .br_resolved  (br_resolved),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .issue        (issue),
    .stall_if     (stall_if),
    .bubble_ex    (bubble_ex),
    .stall_ex     (stall_ex),
    .flush_ifid   (flush_ifid),
    .mem_req      (mem_req)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [AW-1:0] sa, input logic sav,
                        input logic [AW-1:0] sb, input logic sbv, input logic [AW-1:0] rd,
                        input logic wr, input logic ld, input logic st, input logic [1:0] br);
    s_valid = v; s_sa = sa; s_sav = sav; s_sb = sb; s_sbv = sbv;
    s_rd = rd; s_wr = wr; s_ld = ld; s_st = st; s_br = br;
  endtask

  task automatic nop();
    set_id(1'b1, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic alu(input logic [AW-1:0] rd, input logic [AW-1:0] sa);
    set_id(1'b1, sa, 1'b1, '0, 1'b0, rd, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic rd_a(input logic [AW-1:0] sa);
    set_id(1'b1, sa, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic load(input logic [AW-1:0] rd);
    set_id(1'b1, '0, 1'b0, '0, 1'b0, rd, 1'b1, 1'b1, 1'b0, 2'b00);
  endtask

  task automatic branch(input logic [AW-1:0] sa);
    set_id(1'b1, sa, 1'b1, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b01);
  endtask

  // One pipeline cycle: apply staged inputs after the edge and queue the expected outputs.
  task automatic cyc(input string nm, input logic [5:0] e);
    @(posedge clk);
    #1;
    reset = s_reset;
    id_valid = s_valid; id_src_a = s_sa; id_src_a_vld = s_sav;
    id_src_b = s_sb; id_src_b_vld = s_sbv; id_rd = s_rd; id_wr_en = s_wr;
    id_is_load = s_ld; id_is_store = s_st; id_br = s_br;
    br_resolved = s_brres; br_taken = s_brtk; mem_ready = s_mrdy;
    s_brres = 1'b0; s_brtk = 1'b0; s_mrdy = 1'b0;
    name_q.push_back(nm);
    val_q.push_back(e);
  endtask

  initial begin : monitor
    string      nm;
    logic [5:0] e, act;
    forever begin
      @(negedge clk);
      if (val_q.size() != 0) begin
        nm  = name_q.pop_front();
        e   = val_q.pop_front();
        act = {issue, stall_if, bubble_ex, stall_ex, flush_ifid, mem_req};
        n_total++;
        if (act === e) n_pass++;
        else $display("FAIL %s: outputs {issue,stall_if,bubble_ex,stall_ex,flush_ifid,mem_req}=%b, expected %b",
                      nm, act, e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    s_reset = 1'b0;
    nop();
    cyc("rst_hold0", E_NONE);
    cyc("rst_hold1", E_NONE);
    s_reset = 1'b1;
    cyc("nop_after_rst", E_ISSUE);

    alu(5'd3, 5'd1);           cyc("add_r3", E_ISSUE);
    alu(5'd6, 5'd3);           cyc("raw_stall1", E_HAZ);
                               cyc("raw_stall2", E_HAZ);
                               cyc("raw_issue", E_ISSUE);
    alu(5'd7, 5'd0);           cyc("add_r7", E_ISSUE);
    rd_a(5'd4);                cyc("indep_r4", E_ISSUE);
    rd_a(5'd6);                cyc("raw_r6_release", E_ISSUE);
    alu(5'd8, 5'd0);           cyc("add_r8", E_ISSUE);
    set_id(1'b1, 5'd8, 1'b0, 5'd8, 1'b0, '0, 1'b0, 1'b0, 1'b0, 2'b00);
                               cyc("unread_src", E_ISSUE);
    set_id(1'b1, 5'd0, 1'b0, 5'd8, 1'b1, '0, 1'b0, 1'b0, 1'b0, 2'b00);
                               cyc("srcb_haz", E_HAZ);
                               cyc("srcb_issue", E_ISSUE);
    alu(5'd9, 5'd0);           cyc("waw_first", E_ISSUE);
                               cyc("waw_second", E_ISSUE);
    rd_a(5'd9);                cyc("waw_stall1", E_HAZ);
                               cyc("waw_stall2", E_HAZ);
                               cyc("waw_issue", E_ISSUE);

    load(5'd5);                cyc("ld_issue", E_ISSUE);
    rd_a(5'd5);                cyc("ld_wait1", E_MEM);
                               cyc("ld_wait2", E_MEM);
    s_mrdy = 1'b1;             cyc("ld_wait3_rdy", E_MEM);
                               cyc("ld_dep_stall", E_HAZ);
                               cyc("ld_dep_issue", E_ISSUE);
    nop(); s_mrdy = 1'b1;      cyc("stray_mrdy", E_ISSUE);
                               cyc("run_after_stray", E_ISSUE);

    set_id(1'b1, 5'd2, 1'b1, '0, 1'b0, 5'd10, 1'b0, 1'b0, 1'b1, 2'b00);
                               cyc("st_issue", E_ISSUE);
    rd_a(5'd10);               cyc("st_wait1", E_MEM);
                               cyc("st_wait2", E_MEM);
    s_mrdy = 1'b1;             cyc("st_wait3_rdy", E_MEM);
                               cyc("st_no_sb", E_ISSUE);

    load(5'd11);               cyc("ld_min_issue", E_ISSUE);
    rd_a(5'd11); s_mrdy = 1'b1; cyc("ld_min_wait", E_MEM);
                               cyc("ld_min_stall", E_HAZ);
                               cyc("ld_min_issue_dep", E_ISSUE);

    branch(5'd1);              cyc("brt_issue", E_ISSUE);
    nop();                     cyc("brt_wait", E_BR);
    s_brres = 1'b1; s_brtk = 1'b1; cyc("brt_flush", E_BRF);
                               cyc("brt_run", E_ISSUE);
    branch(5'd1);              cyc("brn_issue", E_ISSUE);
    nop();                     cyc("brn_wait", E_BR);
    s_brres = 1'b1;            cyc("brn_resolve", E_BR);
                               cyc("brn_run", E_ISSUE);
    s_brres = 1'b1; s_brtk = 1'b1; cyc("stray_br", E_ISSUE);

    load(5'd12);               cyc("rst_ld_issue", E_ISSUE);
    rd_a(5'd12);               cyc("rst_ld_wait", E_MEM);
    s_reset = 1'b0;            cyc("rst_mid_mem", E_NONE);
                               cyc("rst_mid_mem_hold", E_NONE);
    s_reset = 1'b1;            cyc("dep_after_rst", E_ISSUE);

    branch(5'd2);              cyc("rst_br_issue", E_ISSUE);
    nop();                     cyc("rst_br_wait", E_BR);
    s_reset = 1'b0;            cyc("rst_mid_br", E_NONE);
    s_reset = 1'b1;            cyc("run_after_br_rst", E_ISSUE);

    for (int i = 0; i < 10 && val_q.size() != 0; i++) @(negedge clk);
    #1;
    if (val_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations still pending, expected 0", val_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Issue-stage controller for the vector pipeline. It sits beside the instruction decoder and consumes the decoder's source, destination, write-enable, load/store and branch fields. It keeps a per-register write-pending scoreboard and decides each cycle whether the instruction in ID issues to EX, stalls with a bubble inserted, or waits on a memory handshake or branch resolution. It drives the IF/ID stall, EX bubble, IF/ID flush and data-memory request signals.

## Interface
- REG_ADDR_W, 5 — register address width; 2**REG_ADDR_W scoreboard entries.
- WB_LATENCY, 2 — cycles from ALU issue until the destination is readable. Legal range 1–3.

Ports. Clock is `clk`; reset is `reset`, asynchronous and active-low.
- clk  in  1  — pipeline clock.
- reset  in  1  — async active-low reset.
- id_valid  in  1  — a decoded instruction is present in ID.
- id_src_a, id_src_b  in  REG_ADDR_W  — source register addresses (HDU_A / HDU_B).
- id_src_a_vld, id_src_b_vld  in  1  — the corresponding source is actually read.
- id_rd  in  REG_ADDR_W  — destination register.
- id_wr_en  in  1  — the instruction writes id_rd.
- id_is_load, id_is_store  in  1  — memory instruction.
- id_br  in  2  — branch type; nonzero means branch.
- br_resolved  in  1  — EX has resolved the outstanding branch this cycle.
- br_taken  in  1  — qualifies br_resolved.
- mem_ready  in  1  — memory completes the outstanding request this cycle.
- issue  out  1  — the ID instruction advances to EX this cycle.
- stall_if  out  1  — hold the PC and the IF/ID register.
- bubble_ex  out  1  — load a NOP into ID/EX.
- stall_ex  out  1  — hold ID/EX and EX/MEM (memory wait).
- flush_ifid  out  1  — squash the IF/ID contents (wrong-path instruction).
- mem_req  out  1  — data-memory request, held until mem_ready.

## Operation
State machine: RUN, MEM_WAIT, BR_WAIT.

Scoreboard:
- One counter per register, width ceil(log2(WB_LATENCY+1)).
- Nonzero counters decrement every cycle in all states, except a load destination that is held (see below).
- An ALU issue with id_wr_en=1 loads counter[id_rd]=WB_LATENCY. This overwrites any existing value; a WAW is not a hazard.

Hazard: `(id_src_a_vld && cnt[id_src_a]!=0) || (id_src_b_vld && cnt[id_src_b]!=0)`.

RUN:
- id_valid=0: all outputs 0.
- id_valid=1 with a hazard: stall_if=1, bubble_ex=1, issue=0. State stays RUN.
- id_valid=1, no hazard: issue=1.
  - Load or store: next state MEM_WAIT. For a load, latch id_rd as load_rd and mark it held; hazard checks then see a nonzero count for load_rd.
  - id_br≠0: next state BR_WAIT.
  - Otherwise: stay in RUN.

MEM_WAIT:
- mem_req=1, stall_if=1, stall_ex=1, issue=0.
- On mem_ready: return to RUN. If the operation was a load, set cnt[load_rd]=1 and release the hold.
- mem_ready outside MEM_WAIT is ignored.

BR_WAIT:
- stall_if=1, bubble_ex=1, issue=0.
- On br_resolved:
  - br_taken=1: flush_ifid=1 for that one cycle.
  - Either way, return to RUN.
- The ID instruction is re-evaluated in RUN on the next cycle.

NOP (id_valid=1, no sources, no write, no memory, no branch): issues immediately in RUN.

## Timing
- All outputs are combinational from state, the scoreboard and the ID inputs. All are 0 while reset is low.
- Reset (asynchronous, including mid-MEM_WAIT or mid-BR_WAIT):
  - state → RUN, all counters 0, load hold cleared.
  - mem_req drops immediately, without waiting for a clock edge.
- RAW stall cycles:
  - ALU producer issued in cycle T: a dependent instruction in ID stalls cycles T+1..T+WB_LATENCY and issues at T+WB_LATENCY+1.
  - Load issued in cycle T, mem_ready in cycle T+k: a dependent issues at T+k+2.
- mem_req rises the cycle after load/store issue and falls the cycle after mem_ready. Minimum pulse is 1 cycle (mem_ready in the first MEM_WAIT cycle).
- flush_ifid is a single-cycle pulse, coincident with br_resolved & br_taken.
- issue, stall_if and stall_ex are never high together.

## Test plan
- **Reset behaviour:** assert reset with id_valid=1 → all outputs 0. Release reset, then a NOP in ID → issue=1 that cycle.
- **ALU RAW, WB_LATENCY=2:** ADD r3 issues at cycle 0; SUB reading r3 is in ID → stall_if=bubble_ex=1 in cycles 1–2, issue=1 in cycle 3. An independent instruction reading r4 instead issues in cycle 1.
- **Load with 3-cycle memory:** LD r5 issues at cycle 0 → mem_req=1 in cycles 1–3 with mem_ready in cycle 3; a dependent on r5 issues at cycle 5. A store sequence gives the same mem_req timing with no scoreboard effect.
- **Branch taken:** VBNZ issues at cycle 0; br_resolved=br_taken=1 at cycle 2 → bubble_ex=1 in cycles 1–2, flush_ifid=1 only in cycle 2, RUN in cycle 3.
- **Branch not taken:** same sequence with br_taken=0 → flush_ifid stays 0.
- **Reset mid-MEM_WAIT:** drop reset in cycle 2 of a load wait → mem_req goes to 0 asynchronously. After release, a dependent on the load's rd issues immediately (scoreboard cleared).
